trans_count_reader: RTL and testbench

- Reads back the per-cell-type transition counter memory written by the cell library.
- Scans the entries BUF, INV, NAND, NOR, DFF, DFFSR in that order.
- Weights each count by a per-type energy constant, streams one record per type over a valid/ready handshake, and accumulates a saturating total energy.
- Optionally clears each counter after reading it. Sits between the counter memory and the power-report logic.

---
 rtl/cell_map_pkg.sv | 50 +++++
 rtl/energy_mac.sv | 55 +++++
 rtl/trans_count_reader.sv | 115 +++++++++++
 tb/tb_trans_count_reader.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cell_map_pkg.sv
// Cell-type map shared by the transition counter readback logic:
// entry order, counter addresses, energy weights and scan FSM encoding.
package cell_map_pkg;

    localparam int N_CELLS = 6;
    localparam int IDX_W   = $clog2(N_CELLS);

    localparam int unsigned ADDR_BUF   = 0;
    localparam int unsigned ADDR_INV   = 1;
    localparam int unsigned ADDR_NAND  = 2;
    localparam int unsigned ADDR_NOR   = 3;
    localparam int unsigned ADDR_DFF   = 4;
    localparam int unsigned ADDR_DFFSR = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_CALC,
        ST_SEND,
        ST_CLEAR,
        ST_NEXT,
        ST_DONE
    } state_e;

    function automatic int unsigned cell_addr(input logic [IDX_W-1:0] idx);
        case (idx)
            3'd0:    return ADDR_BUF;
            3'd1:    return ADDR_INV;
            3'd2:    return ADDR_NAND;
            3'd3:    return ADDR_NOR;
            3'd4:    return ADDR_DFF;
            3'd5:    return ADDR_DFFSR;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned cell_weight(input logic [IDX_W-1:0] idx);
        case (idx)
            3'd0:    return 10;
            3'd1:    return 7;
            3'd2:    return 7;
            3'd3:    return 10;
            3'd4:    return 12;
            3'd5:    return 12;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/energy_mac.sv
// Weighted energy multiply with a saturating running total and sticky
// overflow flag; cleared when a new scan is accepted.
module energy_mac #(
    parameter int CNT_W = 32,
    parameter int W_W   = 8,
    parameter int ACC_W = 48
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clr_i,
    input  logic                   en_i,
    input  logic [CNT_W-1:0]       count_i,
    input  logic [W_W-1:0]         weight_i,
    output logic [CNT_W+W_W-1:0]   energy_o,
    output logic [ACC_W-1:0]       total_o,
    output logic                   overflow_o
);

    localparam int E_W   = CNT_W + W_W;
    localparam int SUM_W = ((ACC_W > E_W) ? ACC_W : E_W) + 1;

    logic [E_W-1:0]   energy_q, energy_d;
    logic [ACC_W-1:0] total_q;
    logic             overflow_q;
    logic [SUM_W-1:0] sum;
    logic             sat;

    // The sum is one bit wider than either operand so a carry out of the
    // accumulator is visible even when the product is wider than ACC_W.
    always_comb begin
        energy_d = E_W'(count_i) * E_W'(weight_i);
        sum      = SUM_W'(total_q) + SUM_W'(energy_d);
        sat      = (sum > SUM_W'({ACC_W{1'b1}}));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            energy_q   <= '0;
            total_q    <= '0;
            overflow_q <= 1'b0;
        end else if (clr_i) begin
            total_q    <= '0;
            overflow_q <= 1'b0;
        end else if (en_i) begin
            energy_q   <= energy_d;
            total_q    <= sat ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
            overflow_q <= overflow_q | sat;
        end
    end

    assign energy_o   = energy_q;
    assign total_o    = total_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/trans_count_reader.sv
// Scans the per-cell-type transition counters, streams weighted energy
// records over valid/ready and accumulates the total, optionally clearing.
module trans_count_reader
    import cell_map_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter int ADDR_W        = 4,
    parameter int W_W           = 8,
    parameter int ACC_W         = 48,
    parameter bit CLEAR_ON_READ = 1
) (
    input  logic                   C,
    input  logic                   RN,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   mem_rd,
    input  logic [CNT_W-1:0]       mem_rdata,
    output logic                   mem_wr,
    output logic [CNT_W-1:0]       mem_wdata,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic [ADDR_W-1:0]      rec_addr,
    output logic [CNT_W-1:0]       rec_count,
    output logic [CNT_W+W_W-1:0]   rec_energy,
    output logic [ACC_W-1:0]       total_energy,
    output logic                   overflow
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]  rec_addr_q;
    logic [CNT_W-1:0]   rec_count_q;
    logic [ADDR_W-1:0]  cur_addr;
    logic               accept;

    assign cur_addr = ADDR_W'(cell_addr(idx_q));
    assign accept   = (state_q == ST_IDLE) && start;

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            rec_addr_q  <= '0;
            rec_count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (state_q == ST_WAIT) begin
                rec_addr_q  <= cur_addr;
                rec_count_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    idx_d   = '0;
                end
            end
            ST_READ:  state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_CALC;
            ST_CALC:  state_d = ST_SEND;
            ST_SEND: begin
                if (rec_ready) state_d = CLEAR_ON_READ ? ST_CLEAR : ST_NEXT;
            end
            ST_CLEAR: state_d = ST_NEXT;
            ST_NEXT: begin
                if (idx_q == IDX_W'(N_CELLS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_READ;
                    idx_d   = idx_q + 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    energy_mac #(
        .CNT_W (CNT_W),
        .W_W   (W_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk_i      (C),
        .rst_ni     (RN),
        .clr_i      (accept),
        .en_i       (state_q == ST_CALC),
        .count_i    (rec_count_q),
        .weight_i   (W_W'(cell_weight(idx_q))),
        .energy_o   (rec_energy),
        .total_o    (total_energy),
        .overflow_o (overflow)
    );

    // Memory strobes decode straight from state, so an async reset drops
    // them in the same instant and no half-issued clear can follow.
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign mem_rd    = (state_q == ST_READ);
    assign mem_wr    = (state_q == ST_CLEAR);
    assign mem_addr  = (mem_rd || mem_wr) ? cur_addr : '0;
    assign mem_wdata = '0;
    assign rec_valid = (state_q == ST_SEND);
    assign rec_addr  = rec_addr_q;
    assign rec_count = rec_count_q;

endmodule

// File: tb/tb_trans_count_reader.sv
// Directed bench: clear-on-read scans, ready throttling, no-clear scans,
// saturation on a narrow accumulator, and reset in the middle of a scan.
module tb_trans_count_reader;

    logic C = 1'b0;
    logic RN = 1'b0;
    always #5 C = ~C;

    int n_tests = 0;
    int n_fail  = 0;

    // instance A: defaults (clear on read, 48-bit total)
    logic        start_a = 1'b0, rec_ready_a = 1'b1;
    logic        busy_a, done_a, mem_rd_a, mem_wr_a, rec_valid_a, overflow_a;
    logic [3:0]  mem_addr_a, rec_addr_a;
    logic [31:0] mem_rdata_a, mem_wdata_a, rec_count_a;
    logic [39:0] rec_energy_a;
    logic [47:0] total_a;

    // instance B: no clear, 8-bit total
    logic        start_b = 1'b0, rec_ready_b = 1'b1;
    logic        busy_b, done_b, mem_rd_b, mem_wr_b, rec_valid_b, overflow_b;
    logic [3:0]  mem_addr_b, rec_addr_b;
    logic [31:0] mem_rdata_b, mem_wdata_b, rec_count_b;
    logic [39:0] rec_energy_b;
    logic [7:0]  total_b;

    trans_count_reader dut_a (
        .C(C), .RN(RN), .start(start_a), .busy(busy_a), .done(done_a),
        .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .mem_rdata(mem_rdata_a),
        .mem_wr(mem_wr_a), .mem_wdata(mem_wdata_a), .rec_valid(rec_valid_a),
        .rec_ready(rec_ready_a), .rec_addr(rec_addr_a), .rec_count(rec_count_a),
        .rec_energy(rec_energy_a), .total_energy(total_a), .overflow(overflow_a)
    );

    trans_count_reader #(.ACC_W(8), .CLEAR_ON_READ(1'b0)) dut_b (
        .C(C), .RN(RN), .start(start_b), .busy(busy_b), .done(done_b),
        .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_rdata(mem_rdata_b),
        .mem_wr(mem_wr_b), .mem_wdata(mem_wdata_b), .rec_valid(rec_valid_b),
        .rec_ready(rec_ready_b), .rec_addr(rec_addr_b), .rec_count(rec_count_b),
        .rec_energy(rec_energy_b), .total_energy(total_b), .overflow(overflow_b)
    );

    // counter memories with one-cycle read latency
    logic [31:0] mem_a [16];
    logic [31:0] mem_b [16];
    logic [31:0] init_v [6];
    logic        ld_a = 1'b0, ld_b = 1'b0;
    int          wr_cnt_b = 0;

    always @(posedge C) begin
        if (ld_a) begin
            for (int i = 0; i < 6; i++) mem_a[i] <= init_v[i];
        end else begin
            if (mem_rd_a) mem_rdata_a <= mem_a[mem_addr_a];
            if (mem_wr_a) mem_a[mem_addr_a] <= mem_wdata_a;
        end
    end

    always @(posedge C) begin
        if (ld_b) begin
            for (int i = 0; i < 6; i++) mem_b[i] <= init_v[i];
        end else begin
            if (mem_rd_b) mem_rdata_b <= mem_b[mem_addr_b];
            if (mem_wr_b) begin
                mem_b[mem_addr_b] <= mem_wdata_b;
                wr_cnt_b <= wr_cnt_b + 1;
            end
        end
    end

    logic [3:0]  got_addr [8];
    logic [31:0] got_cnt  [8];
    logic [39:0] got_en   [8];
    int          got_n, got_cyc;
    logic [47:0] got_t1;
    logic        got_o1;

    task automatic load_mem(input bit to_b, input logic [31:0] c0, c1, c2, c3, c4, c5);
        init_v[0] = c0; init_v[1] = c1; init_v[2] = c2;
        init_v[3] = c3; init_v[4] = c4; init_v[5] = c5;
        if (to_b) ld_b = 1'b1; else ld_a = 1'b1;
        @(posedge C); #1;
        ld_a = 1'b0; ld_b = 1'b0;
    endtask

    task automatic scan_a(input bit toggle, input bit poke);
        logic [3:0]  pa;
        logic [31:0] pc;
        logic [39:0] pe;
        logic        hold;
        hold = 1'b0; pa = '0; pc = '0; pe = '0; got_n = 0;
        @(posedge C); #1 start_a = 1'b1;
        @(posedge C); #1 start_a = 1'b0;
        n_tests++;
        if (busy_a !== 1'b1) begin
            n_fail++; $display("FAIL busy_cycle1 got %b exp 1", busy_a);
        end
        got_t1 = total_a; got_o1 = overflow_a;
        got_cyc = 1;
        while (done_a !== 1'b1 && got_cyc < 300) begin
            rec_ready_a = toggle ? (got_cyc % 4 == 0) : 1'b1;
            start_a = poke && (got_cyc == 10);
            n_tests++;
            if (mem_rd_a && mem_wr_a) begin
                n_fail++; $display("FAIL rd_wr_overlap cycle %0d got both high exp exclusive", got_cyc);
            end
            if (hold) begin
                n_tests++;
                if (rec_valid_a !== 1'b1 || rec_addr_a !== pa || rec_count_a !== pc || rec_energy_a !== pe) begin
                    n_fail++;
                    $display("FAIL rec_stable cycle %0d got v=%b a=%0d c=%0d e=%0d exp v=1 a=%0d c=%0d e=%0d",
                             got_cyc, rec_valid_a, rec_addr_a, rec_count_a, rec_energy_a, pa, pc, pe);
                end
            end
            if (rec_valid_a && rec_ready_a) begin
                if (got_n < 8) begin
                    got_addr[got_n] = rec_addr_a; got_cnt[got_n] = rec_count_a; got_en[got_n] = rec_energy_a;
                end
                got_n++;
            end
            hold = rec_valid_a && !rec_ready_a;
            pa = rec_addr_a; pc = rec_count_a; pe = rec_energy_a;
            @(posedge C); #1;
            got_cyc++;
        end
        start_a = 1'b0; rec_ready_a = 1'b1;
        n_tests++;
        if (done_a !== 1'b1) begin
            n_fail++; $display("FAIL done_timeout_a got %b exp 1", done_a);
        end
        n_tests++;
        if (busy_a !== 1'b0) begin
            n_fail++; $display("FAIL busy_at_done got %b exp 0", busy_a);
        end
    endtask

    task automatic scan_b;
        got_n = 0;
        @(posedge C); #1 start_b = 1'b1;
        @(posedge C); #1 start_b = 1'b0;
        got_t1 = 48'(total_b); got_o1 = overflow_b;
        got_cyc = 1;
        while (done_b !== 1'b1 && got_cyc < 300) begin
            rec_ready_b = 1'b1;
            if (rec_valid_b && rec_ready_b) begin
                if (got_n < 8) begin
                    got_addr[got_n] = rec_addr_b; got_cnt[got_n] = rec_count_b; got_en[got_n] = rec_energy_b;
                end
                got_n++;
            end
            @(posedge C); #1;
            got_cyc++;
        end
        n_tests++;
        if (done_b !== 1'b1) begin
            n_fail++; $display("FAIL done_timeout_b got %b exp 1", done_b);
        end
    endtask

    task automatic test_reset;
        #2;
        n_tests++;
        if ({busy_a, done_a, mem_rd_a, mem_wr_a, rec_valid_a, overflow_a} !== 6'b0 ||
            total_a !== 48'd0 || rec_energy_a !== 40'd0 || rec_count_a !== 32'd0 ||
            mem_addr_a !== 4'd0 || rec_addr_a !== 4'd0 || mem_wdata_a !== 32'd0) begin
            n_fail++; $display("FAIL reset_outputs got busy=%b vld=%b total=%0d exp all zero", busy_a, rec_valid_a, total_a);
        end
        @(negedge C); RN = 1'b1;
        @(posedge C); #1;
        n_tests++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset got busy=%b done=%b exp 0 0", busy_a, done_a);
        end
    endtask

    task automatic check_records(input string tag, input int e0, e1, e2, e3, e4, e5,
                                 input int c0, c1, c2, c3, c4, c5);
        int ee [6];
        int ec [6];
        ee = '{e0, e1, e2, e3, e4, e5};
        ec = '{c0, c1, c2, c3, c4, c5};
        n_tests++;
        if (got_n != 6) begin
            n_fail++; $display("FAIL %s_rec_count got %0d exp 6", tag, got_n);
        end
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (got_addr[i] !== 4'(i) || got_cnt[i] !== 32'(ec[i]) || got_en[i] !== 40'(ee[i])) begin
                n_fail++;
                $display("FAIL %s_rec%0d got a=%0d c=%0d e=%0d exp a=%0d c=%0d e=%0d",
                         tag, i, got_addr[i], got_cnt[i], got_en[i], i, ec[i], ee[i]);
            end
        end
    endtask

    task automatic test_scan_basic;
        load_mem(1'b0, 5, 3, 0, 2, 1, 4);
        scan_a(1'b0, 1'b0);
        check_records("basic", 50, 21, 0, 20, 12, 48, 5, 3, 0, 2, 1, 4);
        n_tests++;
        if (got_cyc != 37) begin
            n_fail++; $display("FAIL basic_done_cycle got %0d exp 37", got_cyc);
        end
        n_tests++;
        if (total_a !== 48'd151 || overflow_a !== 1'b0) begin
            n_fail++; $display("FAIL basic_total got %0d ovf %b exp 151 ovf 0", total_a, overflow_a);
        end
        @(posedge C); #1;
        n_tests++;
        if (done_a !== 1'b0 || busy_a !== 1'b0 || total_a !== 48'd151) begin
            n_fail++; $display("FAIL basic_hold got done=%b busy=%b total=%0d exp 0 0 151", done_a, busy_a, total_a);
        end
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (mem_a[i] !== 32'd0) begin
                n_fail++; $display("FAIL basic_cleared%0d got %0d exp 0", i, mem_a[i]);
            end
        end
    endtask

    task automatic test_ready_toggle;
        load_mem(1'b0, 5, 3, 0, 2, 1, 4);
        scan_a(1'b1, 1'b0);
        check_records("toggle", 50, 21, 0, 20, 12, 48, 5, 3, 0, 2, 1, 4);
        n_tests++;
        if (total_a !== 48'd151) begin
            n_fail++; $display("FAIL toggle_total got %0d exp 151", total_a);
        end
    endtask

    task automatic test_start_while_busy;
        load_mem(1'b0, 5, 3, 0, 2, 1, 4);
        scan_a(1'b0, 1'b1);
        check_records("poke", 50, 21, 0, 20, 12, 48, 5, 3, 0, 2, 1, 4);
        n_tests++;
        if (got_cyc != 37 || total_a !== 48'd151) begin
            n_fail++; $display("FAIL poke_result got cycle %0d total %0d exp 37 151", got_cyc, total_a);
        end
        @(posedge C); #1;
        n_tests++;
        if (busy_a !== 1'b0) begin
            n_fail++; $display("FAIL poke_no_restart got busy=%b exp 0", busy_a);
        end
    endtask

    task automatic test_back_to_back;
        int wr0;
        load_mem(1'b1, 5, 3, 0, 2, 1, 4);
        wr0 = wr_cnt_b;
        for (int s = 0; s < 2; s++) begin
            scan_b();
            check_records("noclr", 50, 21, 0, 20, 12, 48, 5, 3, 0, 2, 1, 4);
            n_tests++;
            if (total_b !== 8'd151 || overflow_b !== 1'b0 || got_cyc != 31) begin
                n_fail++; $display("FAIL noclr_scan%0d got total %0d ovf %b cycle %0d exp 151 0 31",
                                   s, total_b, overflow_b, got_cyc);
            end
        end
        n_tests++;
        if (wr_cnt_b != wr0) begin
            n_fail++; $display("FAIL noclr_writes got %0d exp 0", wr_cnt_b - wr0);
        end
        n_tests++;
        if (mem_b[0] !== 32'd5 || mem_b[1] !== 32'd3 || mem_b[2] !== 32'd0 ||
            mem_b[3] !== 32'd2 || mem_b[4] !== 32'd1 || mem_b[5] !== 32'd4) begin
            n_fail++; $display("FAIL noclr_mem got %0d %0d %0d exp 5 3 0", mem_b[0], mem_b[1], mem_b[2]);
        end
    endtask

    task automatic test_saturate;
        load_mem(1'b1, 30, 0, 0, 0, 0, 0);
        scan_b();
        n_tests++;
        if (got_en[0] !== 40'd300) begin
            n_fail++; $display("FAIL sat_buf_energy got %0d exp 300", got_en[0]);
        end
        n_tests++;
        if (total_b !== 8'd255 || overflow_b !== 1'b1) begin
            n_fail++; $display("FAIL sat_total got %0d ovf %b exp 255 ovf 1", total_b, overflow_b);
        end
        load_mem(1'b1, 5, 3, 0, 2, 1, 4);
        scan_b();
        n_tests++;
        if (got_t1 !== 48'd0 || got_o1 !== 1'b0) begin
            n_fail++; $display("FAIL sat_start_clear got %0d ovf %b exp 0 ovf 0", got_t1, got_o1);
        end
        n_tests++;
        if (total_b !== 8'd151 || overflow_b !== 1'b0) begin
            n_fail++; $display("FAIL sat_rescan got %0d ovf %b exp 151 ovf 0", total_b, overflow_b);
        end
    endtask

    task automatic test_reset_mid_send;
        int c;
        load_mem(1'b0, 5, 3, 9, 2, 1, 4);
        @(posedge C); #1 start_a = 1'b1;
        @(posedge C); #1 start_a = 1'b0;
        c = 0;
        while (!(rec_valid_a === 1'b1 && rec_addr_a === 4'd2) && c < 100) begin
            rec_ready_a = 1'b1;
            @(posedge C); #1;
            c++;
        end
        rec_ready_a = 1'b0;
        n_tests++;
        if (c >= 100) begin
            n_fail++; $display("FAIL rst_reach_send got timeout exp entry 2 in SEND");
        end
        #2 RN = 1'b0;
        #1;
        n_tests++;
        if ({busy_a, done_a, mem_rd_a, mem_wr_a, rec_valid_a, overflow_a} !== 6'b0 ||
            total_a !== 48'd0 || rec_count_a !== 32'd0 || rec_energy_a !== 40'd0 || rec_addr_a !== 4'd0) begin
            n_fail++; $display("FAIL rst_async_outputs got busy=%b vld=%b wr=%b total=%0d exp all zero",
                               busy_a, rec_valid_a, mem_wr_a, total_a);
        end
        @(posedge C); @(posedge C); #1;
        n_tests++;
        if (busy_a !== 1'b0 || mem_wr_a !== 1'b0) begin
            n_fail++; $display("FAIL rst_held got busy=%b wr=%b exp 0 0", busy_a, mem_wr_a);
        end
        RN = 1'b1;
        rec_ready_a = 1'b1;
        n_tests++;
        if (mem_a[0] !== 32'd0 || mem_a[1] !== 32'd0 || mem_a[2] !== 32'd9 ||
            mem_a[3] !== 32'd2 || mem_a[4] !== 32'd1 || mem_a[5] !== 32'd4) begin
            n_fail++; $display("FAIL rst_partial_mem got %0d %0d %0d %0d %0d %0d exp 0 0 9 2 1 4",
                               mem_a[0], mem_a[1], mem_a[2], mem_a[3], mem_a[4], mem_a[5]);
        end
        scan_a(1'b0, 1'b0);
        check_records("rescan", 0, 0, 63, 20, 12, 48, 0, 0, 9, 2, 1, 4);
        n_tests++;
        if (total_a !== 48'd143 || got_cyc != 37) begin
            n_fail++; $display("FAIL rescan_total got %0d cycle %0d exp 143 37", total_a, got_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_scan_basic();
        test_ready_toggle();
        test_start_while_busy();
        test_back_to_back();
        test_saturate();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
